// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared defaults, word type and FSM states for the CNN image loader
//
// Purpose: common definitions imported by cnn_img_loader and cnn_img_buffer.
//   DEF_DATA_SIZE / DEF_ADDR_SIZE / DEF_MAX_DIM : default parameter values
//   img_word_t                                  : one signed image word
//   loader_state_e                              : loader FSM states
package cnn_pkg;

  localparam int DEF_DATA_SIZE = 16;
  localparam int DEF_ADDR_SIZE = 16;
  localparam int DEF_MAX_DIM   = 32;

  typedef logic signed [DEF_DATA_SIZE-1:0] img_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/cnn_img_buffer.sv
// rtl/cnn_img_buffer.sv - flat MAX_DIM x MAX_DIM image register array
//
// Purpose: holds the loaded image in row-major order; one write port,
// whole array visible on img for the controller and conv/pool layers.
// Optional build macro: CNN_LOADER_CLEAR_EN adds a clear-above-index port.
// Ports:
//   clk, reset       : clock, synchronous active-high reset (zeroes array)
//   we, idx, data    : single-word write port
//   clear, clear_from: (CNN_LOADER_CLEAR_EN only) zero entries >= clear_from
//   img              : full array read-out
module cnn_img_buffer
  import cnn_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int MAX_DIM   = DEF_MAX_DIM,
  parameter int IDX_W     = $clog2(MAX_DIM*MAX_DIM+1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        we,
  input  logic [IDX_W-1:0]            idx,
  input  logic signed [DATA_SIZE-1:0] data,
`ifdef CNN_LOADER_CLEAR_EN
  input  logic                        clear,
  input  logic [IDX_W-1:0]            clear_from,
`endif
  output logic signed [DATA_SIZE-1:0] img [0:MAX_DIM*MAX_DIM-1]
);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_DIM*MAX_DIM; i++) begin
        img[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_DIM*MAX_DIM; i++) begin
        if (we && (idx == IDX_W'(i))) begin
          img[i] <= data;
        end
`ifdef CNN_LOADER_CLEAR_EN
        else if (clear && (IDX_W'(i) >= clear_from)) begin
          img[i] <= '0;
        end
`endif
      end
    end
  end

endmodule

// File: rtl/cnn_img_loader.sv
// rtl/cnn_img_loader.sv - streams a square image from word memory into a flat buffer
//
// Purpose: on a level load request, reads load_size*load_size words starting at
// load_addr (address wraps) and stores them row-major in img_out, then holds
// load_done until the request drops. Oversized requests finish immediately with
// size_err. Dropping the request mid-load aborts: outstanding returns are
// drained and discarded and load_done is not raised.
// Optional build macro: CNN_LOADER_CLEAR_EN zeroes buffer entries beyond the
// new image when a load starts.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   load_enable/addr/size       : request from the layer controller
//   mem_rd_en/addr/ready        : memory read request handshake
//   mem_rd_data/valid           : in-order read returns
//   img_out                     : image buffer, row-major
//   load_done, size_err         : completion / oversize status (levels)
module cnn_img_loader
  import cnn_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int MAX_DIM   = DEF_MAX_DIM,
  parameter int IDX_W     = $clog2(MAX_DIM*MAX_DIM+1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_enable,
  input  logic [ADDR_SIZE-1:0]        load_addr,
  input  logic [ADDR_SIZE-1:0]        load_size,
  output logic                        mem_rd_en,
  output logic [ADDR_SIZE-1:0]        mem_addr,
  input  logic                        mem_rd_ready,
  input  logic [DATA_SIZE-1:0]        mem_rd_data,
  input  logic                        mem_rd_valid,
  output logic signed [DATA_SIZE-1:0] img_out [0:MAX_DIM*MAX_DIM-1],
  output logic                        load_done,
  output logic                        size_err
);

  loader_state_e          state, state_next;
  logic [ADDR_SIZE-1:0]   base;
  logic [IDX_W-1:0]       total, issued, received;
  logic [IDX_W-1:0]       issued_next, received_next;
  logic [IDX_W-1:0]       side, total_in;
  logic                   aborting;
  logic                   oversize, active, accept, capture, wr_en;

  // Side length is only used for the element count when it fits MAX_DIM,
  // so truncating it to IDX_W bits never loses information on that path.
  assign side     = IDX_W'(load_size);
  assign total_in = side * side;
  assign oversize = load_size > ADDR_SIZE'(MAX_DIM);

  assign active        = (state == ISSUE) || (state == DRAIN);
  // Requests stop the same cycle the controller drops load_enable.
  assign mem_rd_en     = (state == ISSUE) && load_enable;
  assign mem_addr      = (state == ISSUE) ? base + ADDR_SIZE'(issued) : '0;
  assign accept        = mem_rd_en && mem_rd_ready;
  assign capture       = active && mem_rd_valid;
  assign issued_next   = issued + IDX_W'(accept);
  assign received_next = received + IDX_W'(capture);
  // Returns of an aborted load are counted but never written.
  assign wr_en         = capture && !aborting && (received < total);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (load_enable) begin
          if (oversize) begin
            state_next = DONE;
          end else if (total_in == '0) begin
            state_next = DONE;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!load_enable) begin
          state_next = DRAIN;
        end else if (accept && (issued_next == total)) begin
          state_next = (received_next == total) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        // Abort wins over completion so load_done never follows a drop.
        if (aborting || !load_enable) begin
          if (received_next >= issued) begin
            state_next = IDLE;
          end
        end else if (received_next == total) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (!load_enable) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base      <= '0;
      total     <= '0;
      issued    <= '0;
      received  <= '0;
      aborting  <= 1'b0;
      size_err  <= 1'b0;
      load_done <= 1'b0;
    end else begin
      load_done <= 1'b0;
      unique case (state)
        IDLE: begin
          aborting <= 1'b0;
          if (load_enable) begin
            base     <= load_addr;
            total    <= total_in;
            issued   <= '0;
            received <= '0;
            size_err <= oversize;
          end
        end
        ISSUE, DRAIN: begin
          issued   <= issued_next;
          received <= received_next;
          if (!load_enable) begin
            aborting <= 1'b1;
          end
        end
        DONE: begin
          // Registered one cycle behind entry into DONE.
          load_done <= load_enable;
          if (!load_enable) begin
            size_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CNN_LOADER_CLEAR_EN
  logic clear_en;
  assign clear_en = (state == IDLE) && (state_next == ISSUE);
`endif

  cnn_img_buffer #(
    .DATA_SIZE (DATA_SIZE),
    .MAX_DIM   (MAX_DIM),
    .IDX_W     (IDX_W)
  ) u_img_buffer (
    .clk        (clk),
    .reset      (reset),
    .we         (wr_en),
    .idx        (received),
    .data       (mem_rd_data),
`ifdef CNN_LOADER_CLEAR_EN
    .clear      (clear_en),
    .clear_from (total_in),
`endif
    .img        (img_out)
  );

endmodule

// File: tb/tb_cnn_img_loader.sv
// tb/tb_cnn_img_loader.sv - self-checking bench for cnn_img_loader
module tb_cnn_img_loader;
  import cnn_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int MD    = 32;
  localparam int DEPTH = MD*MD;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } pend_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 load_enable;
  logic [AW-1:0]        load_addr;
  logic [AW-1:0]        load_size;
  logic                 mem_rd_en;
  logic [AW-1:0]        mem_addr;
  logic                 mem_rd_ready;
  logic [DW-1:0]        mem_rd_data;
  logic                 mem_rd_valid;
  logic signed [DW-1:0] img_out [0:DEPTH-1];
  logic                 load_done;
  logic                 size_err;

  cnn_img_loader dut (
    .clk          (clk),
    .reset        (reset),
    .load_enable  (load_enable),
    .load_addr    (load_addr),
    .load_size    (load_size),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_ready (mem_rd_ready),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .img_out      (img_out),
    .load_done    (load_done),
    .size_err     (size_err)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:65535];
  img_word_t     img_exp [0:DEPTH-1];
  bit            known [0:DEPTH-1];
  pend_t         pend [$];
  logic [AW-1:0] req_log [$];
  int            cyc = 0;
  int            lat = 1;
  int            rmode = 0;
  int            hold_viol = 0;
  bit            seen_done = 0;
  bit            prev_stall = 0;
  logic [AW-1:0] prev_addr = '0;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic check_img(input string tag);
    int nbad = 0;
    int first = -1;
    for (int k = 0; k < DEPTH; k++) begin
      if (known[k] && (img_out[k] !== img_exp[k])) begin
        nbad++;
        if (first < 0) first = k;
      end
    end
    check($sformatf("%s img mismatches (first idx %0d)", tag, first), nbad, 0);
  endtask

  // Request monitor: samples pre-edge values of the handshake.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (mem_rd_en && mem_rd_ready) begin
        req_log.push_back(mem_addr);
        pend.push_back('{mem_addr, cyc + lat});
      end
      if (prev_stall && mem_rd_en && (mem_addr != prev_addr)) hold_viol++;
      prev_stall = mem_rd_en && !mem_rd_ready;
      prev_addr  = mem_addr;
      if (load_done) seen_done = 1;
    end
  end

  // Memory responder: fixed latency, in order; a request accepted at edge E
  // returns data sampled at edge E+lat.
  initial begin
    forever begin
      @(negedge clk);
      if (rmode == 1)      mem_rd_ready = ~mem_rd_ready;
      else if (rmode == 2) mem_rd_ready = ($urandom_range(0, 3) != 0);
      else                 mem_rd_ready = 1'b1;
      if ((pend.size() > 0) && (pend[0].due == cyc + 1)) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = mem[pend[0].addr];
        void'(pend.pop_front());
      end else begin
        mem_rd_valid = 1'b0;
        mem_rd_data  = DW'($urandom);
      end
    end
  end

  task automatic run_load(input string tag, input logic [AW-1:0] addr, input int size,
                          input int l, input int rm);
    int t0, tot, budget, nbad, first;
    bit over;
    logic [AW-1:0] a;
    @(negedge clk);
    lat = l;
    rmode = rm;
    req_log.delete();
    hold_viol = 0;
    load_addr = addr;
    load_size = AW'(size);
    load_enable = 1'b1;
    t0 = cyc + 1;
    over = (size > MD);
    tot = over ? 0 : size * size;
    budget = 0;
    while (!load_done && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    check({tag, " load_done"}, load_done, 1);
    if (rm == 0) check({tag, " done edge"}, cyc, (tot == 0) ? t0 + 1 : t0 + tot + l + 1);
    check({tag, " size_err"}, size_err, over);
    check({tag, " read count"}, req_log.size(), tot);
    check({tag, " addr hold"}, hold_viol, 0);
    nbad = 0;
    first = -1;
    for (int k = 0; k < req_log.size() && k < tot; k++) begin
      a = addr + AW'(k);
      if (req_log[k] !== a) begin
        nbad++;
        if (first < 0) first = k;
      end
    end
    check($sformatf("%s addr mismatches (first %0d)", tag, first), nbad, 0);
    if (tot > 0) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (k < tot) begin
          a = addr + AW'(k);
          img_exp[k] = img_word_t'(mem[a]);
          known[k] = 1;
        end
`ifdef CNN_LOADER_CLEAR_EN
        else begin
          img_exp[k] = '0;
          known[k] = 1;
        end
`endif
      end
    end
    check_img(tag);
    repeat (2) @(negedge clk);
    check({tag, " done held"}, load_done, 1);
    load_enable = 1'b0;
    @(negedge clk);
    check({tag, " done cleared"}, load_done, 0);
    check({tag, " size_err cleared"}, size_err, 0);
    @(negedge clk);
  endtask

  task automatic abort_test();
    int budget = 0;
    @(negedge clk);
    lat = 3;
    rmode = 0;
    req_log.delete();
    seen_done = 0;
    load_addr = AW'($urandom);
    load_size = 4;
    load_enable = 1'b1;
    while (req_log.size() < 5 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    load_enable = 1'b0;
    repeat (12) @(negedge clk);
    check("abort read count", req_log.size(), 5);
    check("abort load_done", seen_done, 0);
    check("abort mem_rd_en", mem_rd_en, 0);
    // Which of the first returns landed before the drop is not pinned down.
    for (int k = 0; k < 5; k++) known[k] = 0;
    check_img("abort");
  endtask

  task automatic reset_test();
    @(negedge clk);
    lat = 2;
    rmode = 0;
    load_addr = AW'($urandom);
    load_size = 8;
    load_enable = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset mid mem_rd_en", mem_rd_en, 0);
    check("reset mid load_done", load_done, 0);
    for (int k = 0; k < DEPTH; k++) begin
      img_exp[k] = '0;
      known[k] = 1;
    end
    check_img("reset mid");
    reset = 1'b0;
    load_enable = 1'b0;
    repeat (8) @(negedge clk);
    check("post reset mem_rd_en", mem_rd_en, 0);
    check_img("post reset late returns");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    load_enable = 1'b0;
    load_addr = '0;
    load_size = '0;
    mem_rd_ready = 1'b1;
    mem_rd_valid = 1'b0;
    mem_rd_data = '0;
    for (int a = 0; a < 65536; a++) mem[a] = DW'(a);
    for (int k = 0; k < DEPTH; k++) begin
      img_exp[k] = '0;
      known[k] = 1;
    end
    repeat (3) @(negedge clk);
    check("reset mem_rd_en", mem_rd_en, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset load_done", load_done, 0);
    check("reset size_err", size_err, 0);
    check_img("reset");
    reset = 1'b0;

    run_load("basic", 16'h0100, 3, 1, 0);
    for (int a = 0; a < 65536; a++) mem[a] = DW'($urandom);
    run_load("backpressure", AW'($urandom), 2, 1, 1);
    run_load("size33", 16'h1234, 33, 1, 0);
    run_load("size0", 16'h2000, 0, 1, 0);
    run_load("wrap", 16'hFFFE, 2, 2, 0);
    run_load("four", AW'($urandom), 4, 1, 0);
    run_load("two after four", AW'($urandom), 2, 1, 0);
    abort_test();
    run_load("after abort", AW'($urandom), 1, 2, 0);
    reset_test();
    for (int i = 0; i < 5; i++) begin
      run_load($sformatf("rand%0d", i), AW'($urandom), $urandom_range(1, 12),
               $urandom_range(1, 4), (i % 2 == 0) ? 2 : 0);
    end
    run_load("full32", AW'($urandom), 32, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
